// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - depth-parameterised LIFO stack with valid/ready push and pop handshakes
module lifo_stack #(
  parameter int SIZEDATA   = 32,
  parameter int DEPTHSTACK = 8,
  parameter int AFULLTHR   = DEPTHSTACK - 1
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 flush_i,
  input  logic                                 valid_i,
  input  logic [SIZEDATA-1:0]                  data_i,
  output logic                                 ready_o,
  output logic                                 valid_o,
  output logic [SIZEDATA-1:0]                  data_o,
  input  logic                                 ready_i,
  output logic [$clog2(DEPTHSTACK+1)-1:0]      count_o,
  output logic                                 almost_full_o
);

  localparam int CNTW = $clog2(DEPTHSTACK + 1);
  localparam int AW   = $clog2(DEPTHSTACK);

  logic [SIZEDATA-1:0] mem [DEPTHSTACK];
  logic [CNTW-1:0]     cnt;
  logic [AW-1:0]       top_idx;
  logic [AW-1:0]       nxt_idx;
  logic                push;
  logic                pop;

  // Handshake outputs depend only on occupancy, never on the requesting inputs
  always_comb begin
    top_idx       = AW'(cnt - CNTW'(1));
    nxt_idx       = AW'(cnt);
    valid_o       = (cnt != '0);
    ready_o       = (cnt != CNTW'(DEPTHSTACK));
    almost_full_o = (cnt >= CNTW'(AFULLTHR));
    data_o        = valid_o ? mem[top_idx] : '0;
    push          = valid_i && ready_o;
    pop           = valid_o && ready_i;
    count_o       = cnt;
  end

  // Occupancy: flush wins, a simultaneous push and pop leaves the depth unchanged
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (push && !pop) begin
      cnt <= cnt + CNTW'(1);
    end else if (pop && !push) begin
      cnt <= cnt - CNTW'(1);
    end
  end

  // Storage: a push-with-pop overwrites the departing top, a plain push writes above it
  always_ff @(posedge clk_i) begin
    if (!flush_i && push) begin
      if (pop) begin
        mem[top_idx] <= data_i;
      end else begin
        mem[nxt_idx] <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - self-checking bench for lifo_stack with a queue-based reference model
module tb_lifo_stack;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AFT   = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [W-1:0]  data_o;
  logic          ready_i = 1'b0;
  logic [CW-1:0] count_o;
  logic          almost_full_o;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q[$];

  lifo_stack #(.SIZEDATA(W), .DEPTHSTACK(DEPTH), .AFULLTHR(AFT)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i), .valid_i(valid_i),
    .data_i(data_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
    .ready_i(ready_i), .count_o(count_o), .almost_full_o(almost_full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a stack kept as a queue, back element is the top
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i || flush_i) begin
      q.delete();
    end else if (valid_i && q.size() < DEPTH && ready_i && q.size() > 0) begin
      void'(q.pop_back());
      q.push_back(data_i);
    end else if (valid_i && q.size() < DEPTH) begin
      q.push_back(data_i);
    end else if (ready_i && q.size() > 0) begin
      void'(q.pop_back());
    end
  end

  // Every falling edge, all outputs must match the model
  always @(negedge clk_i) begin
    check("m_count", 32'(count_o), 32'(q.size()));
    check("m_valid", 32'(valid_o), 32'(q.size() != 0));
    check("m_ready", 32'(ready_o), 32'(q.size() != DEPTH));
    check("m_afull", 32'(almost_full_o), 32'(q.size() >= AFT));
    check("m_data", 32'(data_o), (q.size() != 0) ? 32'(q[q.size()-1]) : 32'h0);
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    @(posedge clk_i);
    #1;
  endtask

  logic [W-1:0] pop_exp [4];

  initial begin
    pop_exp[0] = 8'h44; pop_exp[1] = 8'h33; pop_exp[2] = 8'h22; pop_exp[3] = 8'h11;

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_count", 32'(count_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_ready", 32'(ready_o), 1);
    check("rst_afull", 32'(almost_full_o), 0);
    check("rst_data", 32'(data_o), 0);
    rstn_i = 1'b1;
    drive(0, 8'h00, 0, 0);

    drive(1, 8'h11, 0, 0);
    drive(1, 8'h22, 0, 0);
    drive(1, 8'h33, 0, 0);
    check("p3_count", 32'(count_o), 3);
    check("p3_data", 32'(data_o), 32'h33);
    check("p3_afull", 32'(almost_full_o), 1);
    check("p3_ready", 32'(ready_o), 1);

    drive(1, 8'h44, 0, 0);
    check("p4_count", 32'(count_o), 4);
    check("p4_ready", 32'(ready_o), 0);
    drive(1, 8'h55, 0, 0);
    drive(1, 8'h55, 0, 0);
    check("full_hold_count", 32'(count_o), 4);
    check("full_hold_data", 32'(data_o), 32'h44);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("pop%0d_data", i), 32'(data_o), 32'(pop_exp[i]));
      drive(0, 8'h00, 1, 0);
    end
    check("empty_valid", 32'(valid_o), 0);
    check("empty_data", 32'(data_o), 0);
    check("empty_count", 32'(count_o), 0);

    drive(0, 8'h00, 1, 0);
    check("underflow_count", 32'(count_o), 0);

    drive(1, 8'h11, 0, 0);
    drive(1, 8'h22, 0, 0);
    check("swap_taken", 32'(data_o), 32'h22);
    drive(1, 8'hAA, 1, 0);
    check("swap_data", 32'(data_o), 32'hAA);
    check("swap_count", 32'(count_o), 2);

    drive(0, 8'h00, 0, 1);
    check("flush_count", 32'(count_o), 0);
    drive(1, 8'h5A, 1, 0);
    check("nobypass_count", 32'(count_o), 1);
    check("nobypass_data", 32'(data_o), 32'h5A);

    drive(1, 8'h66, 0, 0);
    drive(1, 8'h77, 0, 0);
    drive(1, 8'h88, 0, 0);
    check("full2_count", 32'(count_o), 4);
    drive(1, 8'h99, 1, 0);
    check("fullpop_count", 32'(count_o), 3);
    check("fullpop_data", 32'(data_o), 32'h77);
    drive(1, 8'h99, 0, 0);
    check("retry_data", 32'(data_o), 32'h99);
    drive(1, 8'h01, 0, 0);
    drive(0, 8'h00, 1, 0);
    drive(0, 8'h00, 1, 0);
    check("pre_flush_count", 32'(count_o), 2);
    drive(1, 8'h02, 0, 0);
    check("pre_flush_count3", 32'(count_o), 3);
    drive(1, 8'h03, 0, 1);
    check("flushpush_count", 32'(count_o), 0);
    check("flushpush_valid", 32'(valid_o), 0);

    drive(1, 8'hC1, 0, 0);
    drive(1, 8'hC2, 0, 0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    rstn_i = 1'b0;
    #1;
    check("arst_count", 32'(count_o), 0);
    check("arst_valid", 32'(valid_o), 0);
    check("arst_ready", 32'(ready_o), 1);
    check("arst_afull", 32'(almost_full_o), 0);
    check("arst_data", 32'(data_o), 0);
    drive(0, 8'h00, 0, 0);
    rstn_i = 1'b1;
    drive(1, 8'hE7, 0, 0);
    drive(0, 8'h00, 0, 0);
    check("post_rst_data", 32'(data_o), 32'hE7);
    check("post_rst_count", 32'(count_o), 1);

    @(negedge clk_i);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Depth-parameterised LIFO (stack) buffer with valid/ready handshakes on both the push side and the pop side.
- It is the reverse-order companion of the team's FIFO and uses the same stream signalling, so the two are interchangeable at stream boundaries.
- Used for return-address stacks, undo buffers and anywhere data must be consumed in reverse arrival order.

Parameters:
- SIZEDATA, 32, width of each data word in bits.
- DEPTHSTACK, 8, number of entries; must be 2 or more.
- AFULLTHR, DEPTHSTACK-1, occupancy at or above which almost_full_o asserts; range 1..DEPTHSTACK.
- CNTW (localparam), $clog2(DEPTHSTACK+1), width of the occupancy counter.

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- flush_i  input  1  synchronous clear; empties the stack.
- valid_i  input  1  push request.
- data_i  input  SIZEDATA  push data.
- ready_o  output  1  stack can accept a push.
- valid_o  output  1  stack holds at least one entry.
- data_o  output  SIZEDATA  current top-of-stack word.
- ready_i  input  1  consumer accepts the top entry (pop).
- count_o  output  CNTW  current occupancy, 0..DEPTHSTACK.
- almost_full_o  output  1  count_o >= AFULLTHR.

Behaviour:
- Reset is asynchronous, active-low, clock clk_i. During reset:
  - count_o = 0, valid_o = 0, ready_o = 1, almost_full_o = 0, data_o = 0.
  - Memory contents are not reset.
- Storage: register array mem[0..DEPTHSTACK-1]. Occupancy register cnt; the top-of-stack index is cnt-1.
- Combinational outputs:
  - valid_o = (cnt != 0)
  - ready_o = (cnt != DEPTHSTACK)
  - data_o = valid_o ? mem[cnt-1] : 0
  - almost_full_o = (cnt >= AFULLTHR)
- Handshake events: push = valid_i && ready_o; pop = valid_o && ready_i.
  - ready_o does not depend on ready_i, and valid_o does not depend on valid_i. There are no combinational paths from inputs to handshake outputs.
- Per-cycle update, evaluated in priority order:
  1. flush_i = 1: cnt <= 0. Any push or pop in the same cycle is discarded, and mem is untouched.
  2. push and pop together:
     - mem[cnt-1] <= data_i and cnt is unchanged.
     - The consumer takes the old top during this cycle; the new word is the top next cycle.
  3. push only: mem[cnt] <= data_i, cnt <= cnt+1.
  4. pop only: cnt <= cnt-1.
  5. Otherwise: hold.
- Latency:
  - A pushed word appears on data_o the cycle after the push edge.
  - A pop exposes the next-lower entry on the cycle after the pop edge.
- Boundaries:
  - Empty: pop is impossible (valid_o = 0). A simultaneous valid_i and ready_i performs a push only; there is no bypass.
  - Full: push is impossible (ready_o = 0). A pop with valid_i high performs the pop only, and the push retries next cycle when ready_o = 1.
  - cnt never wraps: no underflow below 0 and no overflow above DEPTHSTACK.
- Stream rules:
  - The producer must hold data_i stable while valid_i && !ready_o.
  - data_o is stable while valid_o && !ready_i and no push or flush occurs. A push changes the top; this is intended LIFO behaviour.
- Reset mid-operation immediately empties the stack, and outputs go to their reset values asynchronously.
- All arithmetic is on CNTW bits, and index expressions use only the cnt-1 and cnt forms defined above.

Decomposition:
- Shared package: none. All constants are local parameters.
- Single module. The register array and the counter are small enough that a sub-module adds no value.
- Target implementation size: 120-200 lines.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 with ready_i = 0 (DEPTHSTACK=4, SIZEDATA=8) -> count_o = 3, data_o = 0x33, almost_full_o = 1 (AFULLTHR=3), ready_o = 1.
- Continue: push 0x44 -> count_o = 4, ready_o = 0. Then hold valid_i = 1 with 0x55 for 2 cycles -> no change, data_o = 0x44.
- Full stack, ready_i = 1 for 4 cycles -> pops 0x44, 0x33, 0x22, 0x11 in order. Then valid_o = 0, data_o = 0, count_o = 0.
- Stack holding {0x11, 0x22}, valid_i = 1 with 0xAA and ready_i = 1 for one cycle -> consumer receives 0x22. Next cycle data_o = 0xAA, count_o = 2.
- Empty stack, valid_i = 1 with 0x5A and ready_i = 1 -> push only. Next cycle count_o = 1, data_o = 0x5A.
- Stack holding 3 entries, flush_i = 1 with a simultaneous push -> next cycle count_o = 0, valid_o = 0. rstn_i low mid-pop -> outputs take reset values without waiting for a clock edge.
